// File: rtl/four_bit_full_adder.sv
// Clocked 4-bit ripple-carry adder: four chained full-adder cells feed a
// 5-bit output register, giving {C_out, S_out} = A_in + B_in + C_in one cycle later.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign s       = a_xor_b ^ cin;
  assign cout    = (a & b) | (cin & a_xor_b);

endmodule : fa_cell

module four_bit_full_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic       C_in,
  output logic [3:0] S_out,
  output logic       C_out
);

  // carry[i] is the carry into cell i; carry[4] is the FA3 carry-out.
  logic [4:0] carry;
  logic [3:0] sum;
  logic [4:0] result_d;
  logic [4:0] result_q;

  assign carry[0] = C_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    fa_cell u_fa (
      .a    (A_in[i]),
      .b    (B_in[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    result_d = {carry[4], sum};
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; the async reset clears the register without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 5'h00;
    end else begin
      result_q <= result_d;
    end
  end

  assign S_out = result_q[3:0];
  assign C_out = result_q[4];

endmodule : four_bit_full_adder

// File: tb/tb_four_bit_full_adder.sv
// Self-checking bench for four_bit_full_adder: expected sums are queued when
// operands are driven and compared one clock later against the registered outputs.

module tb_four_bit_full_adder;

  logic       clk;
  logic       rst_n;
  logic [3:0] A_in;
  logic [3:0] B_in;
  logic       C_in;
  logic [3:0] S_out;
  logic       C_out;

  logic [4:0] exp_q[$];
  int vectors;
  int miscompares;

  four_bit_full_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A_in  (A_in),
    .B_in  (B_in),
    .C_in  (C_in),
    .S_out (S_out),
    .C_out (C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Drive operands at the falling edge, queue the expected 5-bit result,
  // then step to just after the rising edge that registers it.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    A_in = a;
    B_in = b;
    C_in = c;
    exp_q.push_back(5'(a) + 5'(b) + 5'(c));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] exp;
    rst_n = 1'b0;
    A_in  = 4'd5;
    B_in  = 4'd6;
    C_in  = 1'b1;
    #1;
    vectors++;
    if ({C_out, S_out} !== 5'h00) begin
      miscompares++;
      $display("FAIL reset_initial: got %h want 00", {C_out, S_out});
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({C_out, S_out} !== 5'h00) begin
      miscompares++;
      $display("FAIL reset_held: got %h want 00", {C_out, S_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(5'(A_in) + 5'(B_in) + 5'(C_in));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if ({C_out, S_out} !== exp || exp !== 5'h0C) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h (0C)", {C_out, S_out}, exp);
    end
  endtask

  task automatic test_basic();
    logic [12:0] table_v [6] = '{
      {4'd5,  4'd6, 1'b0, 4'd0}, {4'd8,  4'd7, 1'b0, 4'd0},
      {4'd15, 4'd0, 1'b1, 4'd0}, {4'd15, 4'd1, 1'b0, 4'd0},
      {4'd15, 4'd15, 1'b1, 4'd0}, {4'd0, 4'd0, 1'b0, 4'd0}
    };
    logic [4:0] want [6] = '{5'h0B, 5'h0F, 5'h10, 5'h10, 5'h1F, 5'h00};
    logic [4:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive(table_v[i][12:9], table_v[i][8:5], table_v[i][4]);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL basic_%0d: scoreboard empty", i);
      end else begin
        exp = exp_q.pop_front();
        vectors++;
        if ({C_out, S_out} !== exp || exp !== want[i]) begin
          miscompares++;
          $display("FAIL basic_%0d: got %h want %h (table %h)", i, {C_out, S_out}, exp, want[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [4:0] exp;
    drive(4'd3, 4'd4, 1'b0);
    exp = exp_q.pop_front();
    A_in = 4'd9;
    B_in = 4'd9;
    C_in = 1'b1;
    #2;
    vectors++;
    if ({C_out, S_out} !== exp) begin
      miscompares++;
      $display("FAIL hold_between_edges: got %h want %h", {C_out, S_out}, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp;
    drive(4'd15, 4'd15, 1'b1);
    exp = exp_q.pop_front();
    vectors++;
    if ({C_out, S_out} !== exp) begin
      miscompares++;
      $display("FAIL midreset_loaded: got %h want %h", {C_out, S_out}, exp);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({C_out, S_out} !== 5'h00) begin
      miscompares++;
      $display("FAIL midreset_async_clear: got %h want 00", {C_out, S_out});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({C_out, S_out} !== 5'h00) begin
      miscompares++;
      $display("FAIL midreset_hold_low: got %h want 00", {C_out, S_out});
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(5'(A_in) + 5'(B_in) + 5'(C_in));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if ({C_out, S_out} !== exp || exp !== 5'h1F) begin
      miscompares++;
      $display("FAIL midreset_reload: got %h want %h", {C_out, S_out}, exp);
    end
  endtask

  task automatic test_exhaustive();
    logic [8:0] v;
    logic [4:0] exp;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      drive(v[8:5], v[4:1], v[0]);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL exhaustive_%0d: scoreboard empty", i);
      end else begin
        exp = exp_q.pop_front();
        vectors++;
        if ({C_out, S_out} !== exp) begin
          miscompares++;
          $display("FAIL exhaustive a=%0d b=%0d c=%0d: got %h want %h",
                   v[8:5], v[4:1], v[0], {C_out, S_out}, exp);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_hold();
    test_async_reset();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_four_bit_full_adder

// File: doc/four_bit_full_adder.md
# four_bit_full_adder

Clocked 4-bit ripple-carry adder. It adds two 4-bit operands and a carry-in, and presents a registered 4-bit sum and carry-out one clock after the operands are sampled. It is a leaf arithmetic block, built from four 1-bit full-adder cells chained through their carries. It has no handshake: it produces a new result every cycle.

## Interface

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk   input   1   rising-edge clock.
- rst_n   input   1   asynchronous, active-low reset.
- A_in   input   4   operand A, unsigned.
- B_in   input   4   operand B, unsigned.
- C_in   input   1   carry-in, weight 1.
- S_out   output   4   registered sum bits [3:0].
- C_out   output   1   registered carry-out, weight 16.

## Operation

- Datapath: four 1-bit full-adder cells, FA0 through FA3.
  - FA0 takes C_in as its carry-in.
  - Each FAi takes A_in[i] and B_in[i], and the carry from FA(i-1).
  - Cell equations: s = a ^ b ^ cin; cout = (a & b) | (cin & (a ^ b)).
- Arithmetic rule: {C_out, S_out} = A_in + B_in + C_in, as a 5-bit unsigned result. The range is 0..31; nothing is lost, so there is no overflow.
- Combinational results (the 4 sum bits and the FA3 carry) go into a 5-bit output register.
- No enable: the register loads on every rising clk edge while rst_n is high.
- Signed interpretation is not provided.
  - The caller may treat operands as two's complement.
  - Signed overflow is not flagged.
- No internal state beyond the 5-bit output register. No state machine.

## Timing

- Latency: exactly 1 cycle.
  - Operands present at rising edge N appear on S_out/C_out after edge N.
  - They hold until edge N+1.
- Throughput: one addition per cycle. Back-to-back operand changes are each reflected on consecutive cycles.
- Input changes between edges have no effect on the outputs until the next edge.
- Reset asserted (rst_n = 0):
  - S_out = 4'h0 and C_out = 0 immediately, independent of clk.
  - Outputs hold at 0 while reset is low.
- Reset released (rst_n 0→1): the first rising edge after release loads the sum of the operands sampled at that edge.
- Reset mid-stream: any pending result is discarded. Outputs return to 0 asynchronously. No partial result survives.
- Critical path: the 4-stage ripple from C_in/A_in[0] to the FA3 carry must meet one clk period.

## Test plan

- Reset: hold rst_n = 0 with operands 4'd5, 4'd6, 1 → S_out = 0, C_out = 0 throughout. Release, one edge → S_out = 4'hC, C_out = 0.
- Basic adds, one cycle apart:
  - A = 5, B = 6, C_in = 0 → S_out = 4'hB, C_out = 0 after the next edge.
  - Then A = 8, B = 7, C_in = 0 → S_out = 4'hF, C_out = 0 on the following cycle.
- Carry ripple and wrap-around: A = 15, B = 0, C_in = 1 → S_out = 0, C_out = 1. A = 15, B = 1, C_in = 0 → S_out = 0, C_out = 1.
- Maximum: A = 15, B = 15, C_in = 1 → S_out = 4'hF, C_out = 1. Minimum: A = 0, B = 0, C_in = 0 → S_out = 0, C_out = 0.
- Async reset mid-operation: with A = 15, B = 15, C_in = 1 registered, pulse rst_n low between edges → outputs go to 0 before the next edge. After release they reload on the next edge.
- Exhaustive: all 512 combinations of {A, B, C_in}, one per cycle → every {C_out, S_out} equals A + B + C_in, one cycle later.
